i2c_master_core: RTL and testbench
==================================

Name: i2c_master_core

Overview:
Synthesizable single-master I2C controller for 7-bit addressing. It performs two transaction types: a one-byte write, or a read of 1..255 bytes. It drives SCL and SDA as open-drain lines and sits between a simple request/response host interface and the board I2C pins. A bus slave model that ACKs address 0x2A and returns programmable read data is the companion verification component.

Parameters:
CLK_FREQ  50000000  system clock frequency in Hz
I2C_FREQ  400000  SCL frequency in Hz
Q = max(1, CLK_FREQ/(4*I2C_FREQ))  derived cycles per quarter-bit (integer floor); 31 at defaults

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request pulse; sampled only when busy=0
rw  in  1  0=write, 1=read; captured with start
addr  in  7  slave address; captured with start
wr_data  in  8  write byte; captured with start
num_bytes  in  8  read byte count; captured with start; 0 treated as 1
rd_data  out  8  last received byte
rd_valid  out  1  one-cycle pulse per received byte
busy  out  1  high from accepted start until STOP completes
done  out  1  one-cycle pulse when STOP completes
ack_err  out  1  set when a slave NACK ends a transaction; cleared by the next accepted start
scl_oe  out  1  1 = pull SCL low, 0 = release (external pull-up)
sda_oe  out  1  1 = pull SDA low, 0 = release
sda_i  in  1  sampled SDA pin level

Behaviour:
- Reset (async, rst_n=0): state IDLE, scl_oe=0, sda_oe=0, rd_data=0, rd_valid=0, busy=0, done=0, ack_err=0, all counters 0. Reset mid-transfer abandons the transfer immediately, releases both lines and issues no STOP.
- Tick generator: a tick fires every Q clk cycles while busy. Each bit occupies 4 ticks: p0 SCL low, SDA updated; p1 SCL released; p2 SCL high, sda_i sampled; p3 SCL pulled low. No clock stretching.
- States: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MACK, STOP.
- IDLE: both lines released. start=1 latches the inputs, sets busy, clears ack_err and enters START. start while busy is ignored.
- START: SDA pulled low while SCL is high, then SCL pulled low (two ticks) -> ADDR.
- ADDR: shifts {addr, rw} MSB first, 8 bits -> ADDR_ACK.
- ADDR_ACK: SDA released; samples sda_i at p2.
  - 1 (NACK): ack_err=1 -> STOP.
  - 0: rw=0 -> WRITE; rw=1 -> READ.
- WRITE: shifts wr_data MSB first -> WRITE_ACK. NACK there sets ack_err. Always -> STOP.
- READ: SDA released; 8 bits sampled at p2 MSB first. After bit 0: rd_data updated and rd_valid pulsed once -> MACK.
- MACK: master drives ACK (SDA low) if bytes remain, else NACK (released). Bytes remain -> READ; otherwise -> STOP.
- STOP: SDA low with SCL low, SCL released, then SDA released while SCL is high. Then busy=0, done pulses 1 cycle -> IDLE.
- done and rd_valid never assert in the same cycle. busy deasserts in the cycle done pulses.

Test Plan:
- Write: rw=0, addr=0x2A, wr_data=0x74, slave ACKs -> bus shows START, 0x54, ACK, 0x74, ACK, STOP; done=1 once, ack_err=0, busy spans the whole transfer.
- Single read: rw=1, addr=0x2A, num_bytes=1, slave returns 0xA5 -> address byte 0x55; rd_valid pulses once with rd_data=0xA5; master NACKs, then STOP; done=1.
- Multi read: num_bytes=3, slave returns 0x11, 0x22, 0x33 -> three rd_valid pulses in that order; master sends ACK, ACK, NACK; then STOP.
- Address NACK: addr=0x10, no slave responds -> ack_err=1, no data phase, STOP issued, done=1. The next start clears ack_err.
- Reset mid-read: rst_n=0 during the second data bit -> scl_oe=0, sda_oe=0, busy=0 immediately. A fresh write then completes normally.
- start pulsed while busy=1 -> ignored; exactly one done for the original transfer.

Source files
------------

// File: rtl/i2c_master_core_if.sv
// Host-side request/response signals plus the open-drain pin controls of
// the single-master I2C core, bundled so the core and its user share one port.
interface i2c_master_core_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wr_data;
    logic [7:0] num_bytes;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;

    // Side that issues requests and watches the results.
    modport master (
        output start, rw, addr, wr_data, num_bytes, sda_i,
        input  rd_data, rd_valid, busy, done, ack_err, scl_oe, sda_oe
    );

    // Side implemented by the I2C core itself.
    modport slave (
        input  start, rw, addr, wr_data, num_bytes, sda_i,
        output rd_data, rd_valid, busy, done, ack_err, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_master_core.sv
// Single-master I2C controller, 7-bit addressing: one-byte write or a read of
// 1..255 bytes. SCL/SDA are driven open-drain through scl_oe/sda_oe.
// Every bit spans four ticks: p0 SCL low + SDA update, p1 SCL release,
// p2 SCL high + SDA sample, p3 SCL pulled low again.
module i2c_master_core #(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 400000
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_master_core_if.slave   bus
);
    localparam int QRAW = CLK_FREQ / (4 * I2C_FREQ);
    localparam int Q    = (QRAW < 1) ? 1 : QRAW;
    localparam int QW   = (Q > 1) ? $clog2(Q) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MACK, STOP
    } state_t;

    state_t          state_q;
    logic [QW-1:0]   qcnt_q;
    logic [1:0]      ph_q;
    logic [2:0]      bit_q;
    logic [7:0]      shreg_q;
    logic [6:0]      addr_q;
    logic            rw_q;
    logic [7:0]      wr_data_q;
    logic [7:0]      left_q;
    logic            ackbit_q;
    logic [7:0]      rd_data_q;
    logic            rd_valid_q;
    logic            busy_q;
    logic            done_q;
    logic            ack_err_q;
    logic            scl_oe_q;
    logic            sda_oe_q;
    logic            tick;

    assign tick = busy_q && (qcnt_q == QW'(Q - 1));

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ack_err  = ack_err_q;
    assign bus.scl_oe   = scl_oe_q;
    assign bus.sda_oe   = sda_oe_q;

    // Quarter-bit timer: free-runs only while a transfer is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            qcnt_q <= '0;
        else if (!busy_q || tick)
            qcnt_q <= '0;
        else
            qcnt_q <= qcnt_q + QW'(1);
    end

    // Transfer sequencer with registered pin controls and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wr_data_q  <= '0;
            left_q     <= '0;
            ackbit_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    scl_oe_q <= 1'b0;
                    sda_oe_q <= 1'b0;
                    if (bus.start) begin
                        addr_q    <= bus.addr;
                        rw_q      <= bus.rw;
                        wr_data_q <= bus.wr_data;
                        left_q    <= (bus.num_bytes == 8'd0) ? 8'd1 : bus.num_bytes;
                        busy_q    <= 1'b1;
                        ack_err_q <= 1'b0;
                        ph_q      <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    // First tick: SDA falls under high SCL; second: SCL falls.
                    if (tick) begin
                        if (ph_q == 2'd0) begin
                            sda_oe_q <= 1'b1;
                            ph_q     <= 2'd1;
                        end else begin
                            scl_oe_q <= 1'b1;
                            ph_q     <= 2'd0;
                            bit_q    <= 3'd7;
                            shreg_q  <= {addr_q, rw_q};
                            state_q  <= ADDR;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        ph_q <= ph_q + 2'd1;
                        case (ph_q)
                            2'd0: begin
                                scl_oe_q <= 1'b1;
                                case (state_q)
                                    ADDR, WRITE: sda_oe_q <= ~shreg_q[7];
                                    MACK:        sda_oe_q <= (left_q != 8'd0);
                                    STOP:        sda_oe_q <= 1'b1;
                                    default:     sda_oe_q <= 1'b0;
                                endcase
                            end
                            2'd1: scl_oe_q <= 1'b0;
                            2'd2: begin
                                case (state_q)
                                    ADDR_ACK, WRITE_ACK: ackbit_q <= bus.sda_i;
                                    READ:    shreg_q  <= {shreg_q[6:0], bus.sda_i};
                                    STOP:    sda_oe_q <= 1'b0;
                                    default: ;
                                endcase
                            end
                            default: begin
                                // STOP leaves SCL released; every other bit ends with SCL low.
                                scl_oe_q <= (state_q != STOP);
                                case (state_q)
                                    ADDR, WRITE: begin
                                        shreg_q <= {shreg_q[6:0], 1'b0};
                                        bit_q   <= bit_q - 3'd1;
                                        if (bit_q == 3'd0)
                                            state_q <= (state_q == ADDR) ? ADDR_ACK : WRITE_ACK;
                                    end
                                    ADDR_ACK: begin
                                        bit_q <= 3'd7;
                                        if (ackbit_q) begin
                                            ack_err_q <= 1'b1;
                                            state_q   <= STOP;
                                        end else if (rw_q) begin
                                            state_q <= READ;
                                        end else begin
                                            shreg_q <= wr_data_q;
                                            state_q <= WRITE;
                                        end
                                    end
                                    WRITE_ACK: begin
                                        if (ackbit_q)
                                            ack_err_q <= 1'b1;
                                        state_q <= STOP;
                                    end
                                    READ: begin
                                        bit_q <= bit_q - 3'd1;
                                        if (bit_q == 3'd0) begin
                                            rd_data_q  <= shreg_q;
                                            rd_valid_q <= 1'b1;
                                            left_q     <= left_q - 8'd1;
                                            state_q    <= MACK;
                                        end
                                    end
                                    MACK: begin
                                        bit_q   <= 3'd7;
                                        state_q <= (left_q != 8'd0) ? READ : STOP;
                                    end
                                    default: begin
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                        state_q <= IDLE;
                                    end
                                endcase
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: open-drain bus with a behavioural slave at 0x2A,
// randomized write/read transfers checked against frame-level expectations.
module tb_i2c_master_core;
    localparam int CLK_FREQ = 1200000;
    localparam int I2C_FREQ = 100000;
    localparam logic [6:0] SLV_ADDR = 7'h2A;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    i2c_master_core_if bus();

    i2c_master_core #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Open-drain bus with pull-ups.
    logic slv_drv = 1'b0;
    wire  scl_line = ~bus.scl_oe;
    wire  sda_line = ~(bus.sda_oe | slv_drv);
    assign bus.sda_i = sda_line;

    int n_pass = 0;
    int n_total = 0;

    // Slave model state; frames hold {byte, ack bit} for every 9-clock group.
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    bit         active = 1'b0;
    bit         nacked = 1'b0;
    int         nbits = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         sk, sj;
    logic [7:0] sh = '0;
    logic [7:0] addr_byte = '0;
    logic [7:0] cur;
    logic [8:0] frames[$];
    logic [7:0] slv_data[$];

    always @(scl_line or sda_line or rst_n) begin
        if (!rst_n) begin
            active  = 1'b0;
            slv_drv = 1'b0;
        end else if (scl_line && prev_scl && prev_sda && !sda_line) begin
            active = 1'b1;
            nacked = 1'b0;
            nbits  = 0;
            start_cnt++;
        end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
            if (active) stop_cnt++;
            active = 1'b0;
        end else if (scl_line && !prev_scl && active) begin
            sk = nbits / 9;
            sj = nbits % 9;
            if (sj < 8) begin
                sh = {sh[6:0], sda_line};
                if (sk == 0 && sj == 7) addr_byte = sh;
            end else begin
                frames.push_back({sh, sda_line});
                if (sk > 0 && addr_byte[0] && sda_line) nacked = 1'b1;
            end
            nbits++;
        end else if (!scl_line && prev_scl && active) begin
            sk = nbits / 9;
            sj = nbits % 9;
            slv_drv = 1'b0;
            if (sk == 0) begin
                slv_drv = (sj == 8) && (addr_byte[7:1] == SLV_ADDR);
            end else if (addr_byte[7:1] == SLV_ADDR && !nacked) begin
                if (addr_byte[0]) begin
                    if (sj < 8 && (sk - 1) < slv_data.size()) begin
                        cur = slv_data[sk - 1];
                        slv_drv = !cur[7 - sj];
                    end
                end else begin
                    slv_drv = (sj == 8);
                end
            end
        end
        prev_scl = scl_line;
        prev_sda = sda_line;
    end

    // Output monitor.
    int         done_cnt = 0;
    int         overlap = 0;
    int         busy_at_done = 0;
    logic [7:0] rdq[$];
    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            if (bus.busy) busy_at_done++;
        end
        if (bus.rd_valid) rdq.push_back(bus.rd_data);
        if (bus.done && bus.rd_valid) overlap++;
    end

    task automatic start_pulse(input logic rw, input logic [6:0] a,
                               input logic [7:0] wd, input logic [7:0] nb);
        @(negedge clk);
        bus.start = 1'b1; bus.rw = rw; bus.addr = a;
        bus.wr_data = wd; bus.num_bytes = nb;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output bit timeout, output bit busy_gap);
        timeout = 1'b1;
        busy_gap = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (bus.done) begin
                timeout = 1'b0;
                break;
            end
            if (!bus.busy) busy_gap = 1'b1;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.scl_oe, bus.sda_oe} !== 2'b00) $display("FAIL reset_lines got %b exp 00", {bus.scl_oe, bus.sda_oe});
        else n_pass++;
        n_total++;
        if ({bus.busy, bus.done, bus.rd_valid, bus.ack_err} !== 4'b0000)
            $display("FAIL reset_status got %b exp 0000", {bus.busy, bus.done, bus.rd_valid, bus.ack_err});
        else n_pass++;
        n_total++;
        if (bus.rd_data !== 8'h00) $display("FAIL reset_rd_data got %h exp 00", bus.rd_data);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write(input logic [7:0] wd);
        int f0, s0, p0, d0;
        bit to, gap;
        f0 = frames.size(); s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt;
        start_pulse(1'b0, SLV_ADDR, wd, 8'd0);
        wait_done(to, gap);
        n_total++;
        if (to || gap) $display("FAIL write_busy timeout=%0d gap=%0d exp 0 0", to, gap);
        else n_pass++;
        n_total++;
        if (frames.size() - f0 !== 2) $display("FAIL write_nframes got %0d exp 2", frames.size() - f0);
        else n_pass++;
        if (frames.size() - f0 == 2) begin
            n_total++;
            if (frames[f0] !== {SLV_ADDR, 1'b0, 1'b0}) $display("FAIL write_addr got %h exp %h", frames[f0], {SLV_ADDR, 1'b0, 1'b0});
            else n_pass++;
            n_total++;
            if (frames[f0 + 1] !== {wd, 1'b0}) $display("FAIL write_data got %h exp %h", frames[f0 + 1], {wd, 1'b0});
            else n_pass++;
        end
        n_total++;
        if ({start_cnt - s0, stop_cnt - p0, done_cnt - d0} !== {32'd1, 32'd1, 32'd1})
            $display("FAIL write_events start=%0d stop=%0d done=%0d exp 1 1 1", start_cnt - s0, stop_cnt - p0, done_cnt - d0);
        else n_pass++;
        n_total++;
        if (bus.ack_err !== 1'b0) $display("FAIL write_ack_err got %b exp 0", bus.ack_err);
        else n_pass++;
    endtask

    task automatic test_read(input logic [7:0] nb);
        int f0, r0, d0, n;
        bit to, gap;
        n = (nb == 0) ? 1 : int'(nb);
        slv_data.delete();
        for (int i = 0; i < n; i++) slv_data.push_back(8'($urandom));
        f0 = frames.size(); r0 = rdq.size(); d0 = done_cnt;
        start_pulse(1'b1, SLV_ADDR, 8'h00, nb);
        wait_done(to, gap);
        n_total++;
        if (to || gap) $display("FAIL read_busy n=%0d timeout=%0d gap=%0d exp 0 0", n, to, gap);
        else n_pass++;
        n_total++;
        if (frames.size() - f0 !== n + 1) $display("FAIL read_nframes got %0d exp %0d", frames.size() - f0, n + 1);
        else n_pass++;
        n_total++;
        if (rdq.size() - r0 !== n) $display("FAIL read_nvalid got %0d exp %0d", rdq.size() - r0, n);
        else n_pass++;
        if (frames.size() - f0 == n + 1 && rdq.size() - r0 == n) begin
            n_total++;
            if (frames[f0] !== {SLV_ADDR, 1'b1, 1'b0}) $display("FAIL read_addr got %h exp %h", frames[f0], {SLV_ADDR, 1'b1, 1'b0});
            else n_pass++;
            for (int i = 0; i < n; i++) begin
                n_total++;
                if (frames[f0 + 1 + i] !== {slv_data[i], (i == n - 1)})
                    $display("FAIL read_frame%0d got %h exp %h", i, frames[f0 + 1 + i], {slv_data[i], (i == n - 1)});
                else n_pass++;
                n_total++;
                if (rdq[r0 + i] !== slv_data[i]) $display("FAIL read_data%0d got %h exp %h", i, rdq[r0 + i], slv_data[i]);
                else n_pass++;
            end
        end
        n_total++;
        if (done_cnt - d0 !== 1 || bus.ack_err !== 1'b0)
            $display("FAIL read_done done=%0d ack_err=%b exp 1 0", done_cnt - d0, bus.ack_err);
        else n_pass++;
    endtask

    task automatic test_addr_nack();
        int f0, r0, d0;
        bit to, gap;
        f0 = frames.size(); r0 = rdq.size(); d0 = done_cnt;
        start_pulse(1'b1, 7'h10, 8'h00, 8'd2);
        wait_done(to, gap);
        n_total++;
        if (to) $display("FAIL nack_timeout got 1 exp 0");
        else n_pass++;
        n_total++;
        if (bus.ack_err !== 1'b1) $display("FAIL nack_ack_err got %b exp 1", bus.ack_err);
        else n_pass++;
        n_total++;
        if (frames.size() - f0 !== 1 || rdq.size() - r0 !== 0 || done_cnt - d0 !== 1)
            $display("FAIL nack_shape frames=%0d valids=%0d done=%0d exp 1 0 1", frames.size() - f0, rdq.size() - r0, done_cnt - d0);
        else n_pass++;
        if (frames.size() - f0 == 1) begin
            n_total++;
            if (frames[f0] !== {7'h10, 1'b1, 1'b1}) $display("FAIL nack_frame got %h exp %h", frames[f0], {7'h10, 1'b1, 1'b1});
            else n_pass++;
        end
        start_pulse(1'b0, SLV_ADDR, 8'h3C, 8'd0);
        n_total++;
        if (bus.ack_err !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL nack_clear ack_err=%b busy=%b exp 0 1", bus.ack_err, bus.busy);
        else n_pass++;
        wait_done(to, gap);
        n_total++;
        if (to || bus.ack_err !== 1'b0) $display("FAIL nack_next timeout=%0d ack_err=%b exp 0 0", to, bus.ack_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        bit reached;
        slv_data.delete();
        slv_data.push_back(8'h00);
        slv_data.push_back(8'h00);
        start_pulse(1'b1, SLV_ADDR, 8'h00, 8'd2);
        reached = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (nbits >= 11) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_total++;
        if (!reached) $display("FAIL midrd_reach got 0 exp 1");
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.scl_oe, bus.sda_oe, bus.busy} !== 3'b000)
            $display("FAIL midrd_release got %b exp 000", {bus.scl_oe, bus.sda_oe, bus.busy});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_write(8'($urandom));
    endtask

    task automatic test_back_to_back();
        int f0, d0;
        bit to, gap;
        logic [7:0] wd;
        wd = 8'($urandom);
        f0 = frames.size(); d0 = done_cnt;
        start_pulse(1'b0, SLV_ADDR, wd, 8'd0);
        repeat (40) @(negedge clk);
        start_pulse(1'b1, 7'h15, 8'hFF, 8'd3);
        wait_done(to, gap);
        repeat (400) @(negedge clk);
        n_total++;
        if (to || done_cnt - d0 !== 1 || bus.busy !== 1'b0)
            $display("FAIL b2b_done timeout=%0d done=%0d busy=%b exp 0 1 0", to, done_cnt - d0, bus.busy);
        else n_pass++;
        n_total++;
        if (frames.size() - f0 !== 2) $display("FAIL b2b_nframes got %0d exp 2", frames.size() - f0);
        else n_pass++;
        if (frames.size() - f0 == 2) begin
            n_total++;
            if (frames[f0 + 1] !== {wd, 1'b0}) $display("FAIL b2b_data got %h exp %h", frames[f0 + 1], {wd, 1'b0});
            else n_pass++;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0;
        bus.wr_data = '0; bus.num_bytes = '0;
        test_reset();
        test_write(8'h74);
        slv_data.delete();
        test_read(8'd1);
        test_read(8'd3);
        test_read(8'd0);
        for (int i = 0; i < 3; i++) begin
            test_write(8'($urandom));
            test_read(8'($urandom_range(1, 4)));
        end
        test_addr_nack();
        test_reset_mid_read();
        test_back_to_back();
        n_total++;
        if (overlap !== 0 || busy_at_done !== 0)
            $display("FAIL pulse_rules overlap=%0d busy_at_done=%0d exp 0 0", overlap, busy_at_done);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
